axi_burst_mem_responder: RTL and testbench
==========================================

# axi_burst_mem_responder

AXI responder (slave end) for the team's AXI master FSM: accepts single-beat writes with byte strobes, issues write responses on the B channel, and serves incrementing read bursts of `M_BLEN+1` beats with `S_RLAST`. It backs a word-indexed, byte-enabled memory. It sits opposite the master FSM on the AW/W/B/AR/R channels and adds the B channel and `RLAST`/`RRESP` signalling.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters
- `DEPTH`, 16 — number of 32-bit words; addresses `0..DEPTH-1` are valid.
- `AW`, 32 — address width.

Ports
- `S_ACLK`  in  1  clock
- `S_ARESET`  in  1  synchronous reset, active-high
- `M_AWVALID`  in  1  write-address valid
- `M_AWADDR`  in  AW  write word index
- `S_AWREADY`  out  1  write-address ready
- `M_WVALID`  in  1  write-data valid
- `M_WDATA`  in  32  write data
- `M_WSTRB`  in  4  byte enables; bit i selects bits 8i+7:8i
- `S_WREADY`  out  1  write-data ready
- `S_BVALID`  out  1  write response valid
- `S_BRESP`  out  2  00 OKAY, 10 SLVERR
- `M_BREADY`  in  1  write response ready
- `M_ARVALID`  in  1  read-address valid
- `M_ARADDR`  in  AW  read start word index
- `M_BLEN`  in  4  burst length minus one
- `S_ARREADY`  out  1  read-address ready
- `S_RVALID`  out  1  read data valid
- `S_RDATA`  out  32  read data
- `S_RRESP`  out  2  per-beat response
- `S_RLAST`  out  1  final beat of burst
- `M_RREADY`  in  1  read data ready

## Operation
- Write path and read path are independent FSMs that run concurrently.
- Write FSM states:
  - `W_IDLE`: `S_AWREADY = !aw_got`, `S_WREADY = !w_got`. AW and W are accepted in either order, or in the same cycle. Each is latched on its handshake and its ready drops.
  - When both are held, or arrive on this edge, the block commits and moves to `W_RESP`.
  - Commit, in-range address: strobed bytes are written, unstrobed bytes are kept, `S_BRESP=00`.
  - Commit, address ≥ `DEPTH`: no write, `S_BRESP=10`.
  - `W_RESP`: `S_BVALID=1` and both readies are 0. On `M_BREADY` the block returns to `W_IDLE` and clears `aw_got`/`w_got`.
- Read FSM states:
  - `R_IDLE`: `S_ARREADY=1`. On handshake, latch address `A` and count `M_BLEN`, load beat 0, and move to `R_DATA`.
  - `R_DATA`: `S_RVALID=1`, `S_ARREADY=0`.
    - Beat k carries address `A+k`.
    - In-range beat: `S_RDATA = mem[A+k]`, `S_RRESP=00`.
    - Out-of-range beat: `S_RDATA=0`, `S_RRESP=10`. Addresses do not wrap.
    - `S_RLAST=1` only on beat `M_BLEN`.
    - Outputs are held stable while `M_RREADY=0`.
    - On a handshake of the last beat, return to `R_IDLE`; otherwise load the next beat.
- `S_RDATA` is registered. A beat captures memory as it was before any write committing on the same edge.

## Timing
- Reset values:
  - All `*READY`, `S_BVALID`, `S_RVALID` and `S_RLAST` are 0.
  - `S_BRESP`, `S_RRESP` and `S_RDATA` are 0.
  - Memory is cleared to 0 and both FSMs go idle.
  - `S_AWREADY`, `S_WREADY` and `S_ARREADY` rise in the first cycle after `S_ARESET` falls.
- Write latency: `S_BVALID` is high in the cycle after the later of the AW and W handshakes. The memory is updated on that same edge.
- Read latency: beat 0 is valid in the cycle after the AR handshake. With `M_RREADY` held high, beats are back-to-back, one per cycle.
- Next-transaction readiness:
  - `S_ARREADY` returns in the cycle after the last R handshake.
  - AW/W readies return in the cycle after the B handshake.
- No `VALID` output depends combinationally on any `READY` input.
- Reset mid-transaction aborts it immediately:
  - Outputs take their reset values on the next edge.
  - No partial write is committed unless the commit edge precedes reset.
- `M_BLEN=15` gives a 16-beat burst. A 4-bit beat counter is sufficient.

## Structure
- Package `axi_pkg`:
  - `RESP_OKAY=2'b00` and `RESP_SLVERR=2'b10`.
  - Write state enum {`W_IDLE`, `W_RESP`} and read state enum {`R_IDLE`, `R_DATA`}.
- Sub-module `axi_wstrb_mem` holds the byte-enabled memory:
  - `DEPTH`×32 array with synchronous clear.
  - One write port with a 4-bit strobe.
  - One combinational read port.
- The top level holds both FSMs, the address range checks and the output registers.

## Test plan
- **Byte write, word read:** AW 0 and W `0x12345678`/strobe `0001` in the same cycle. Expect BVALID next cycle with BRESP 00. Then AR 0 with BLEN 0: one beat of `0x00000078`, RLAST=1, RRESP 00.
- **Split AW/W and merge:**
  - W `0x87654321`/strobe `0011` three cycles before AW 1: WREADY drops after W; BVALID comes the cycle after AW.
  - Then W `0x45758264`/strobe `0111` to address 1.
  - Expected: `mem[1]` becomes `0x00758264`.
- **Back-pressured B:** hold BREADY=0 for 5 cycles. BVALID and BRESP stay stable, and AWREADY/WREADY stay 0, until BREADY is asserted.
- **Burst with RREADY stalls:** preload words 0..3 with `0xA0..0xA3`, then AR 0 with BLEN 3 and RREADY toggling 1/0. Expect four beats `A0..A3` in order, data held during stalls, RLAST only on `A3`, and ARREADY back one cycle after.
- **Out-of-range:**
  - AW 20 with DEPTH 16 → BRESP 10 and memory unchanged.
  - AR 14 with BLEN 3 → beats 14 and 15 return RRESP 00; beats 16 and 17 return data 0 with RRESP 10; RLAST on the 4th beat.
- **Reset mid-burst:** assert S_ARESET during beat 2 of a 4-beat read. Next cycle: RVALID=0, RLAST=0, all memory reads 0. ARREADY=1 in the cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared response codes, FSM state types and byte-merge helper for the
// AXI burst memory responder.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   function automatic logic [1:0] resp_of(input logic in_range);
      return in_range ? RESP_OKAY : RESP_SLVERR;
   endfunction

   // Strobed bytes come from the new word, the rest are kept.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_w[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_w[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_wstrb_mem.sv
// Word-indexed, byte-enabled memory: synchronous clear, one strobed write
// port and one combinational read port.
module axi_wstrb_mem
   import axi_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = 4
) (
   input  logic          i_clk,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [3:0]    i_wstrb,
   input  logic [IW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Storage: clear wins over a write on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= merge_bytes(r_mem[i_waddr], i_wdata, i_wstrb);
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_burst_mem_responder.sv
// AXI responder: single-beat strobed writes with B response, incrementing
// read bursts of M_BLEN+1 beats with RLAST; independent write and read FSMs.
module axi_burst_mem_responder
   import axi_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic          S_ACLK,
   input  logic          S_ARESET,
   input  logic          M_AWVALID,
   input  logic [AW-1:0] M_AWADDR,
   output logic          S_AWREADY,
   input  logic          M_WVALID,
   input  logic [31:0]   M_WDATA,
   input  logic [3:0]    M_WSTRB,
   output logic          S_WREADY,
   output logic          S_BVALID,
   output logic [1:0]    S_BRESP,
   input  logic          M_BREADY,
   input  logic          M_ARVALID,
   input  logic [AW-1:0] M_ARADDR,
   input  logic [3:0]    M_BLEN,
   output logic          S_ARREADY,
   output logic          S_RVALID,
   output logic [31:0]   S_RDATA,
   output logic [1:0]    S_RRESP,
   output logic          S_RLAST,
   input  logic          M_RREADY
);

   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

   // Write path state
   wstate_t       r_wstate, w_wstate_nxt;
   logic          r_aw_got, w_aw_got_nxt, r_w_got, w_w_got_nxt;
   logic [AW-1:0] r_awaddr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic          r_awready, w_awready_nxt, r_wready, w_wready_nxt;
   logic          r_bvalid, w_bvalid_nxt;
   logic [1:0]    r_bresp, w_bresp_nxt;
   logic          w_aw_hs, w_w_hs, w_commit, w_w_inrange;
   logic [AW-1:0] w_waddr;
   logic [31:0]   w_wdata;
   logic [3:0]    w_wstrb;

   // Read path state
   rstate_t       r_rstate, w_rstate_nxt;
   logic [AW-1:0] r_raddr;
   logic [3:0]    r_rlen, r_beat, w_beat_nxt, w_beat_inc;
   logic          r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt;
   logic [31:0]   r_rdata, w_rdata_nxt, w_mem_rdata;
   logic [1:0]    r_rresp, w_rresp_nxt;
   logic          r_rlast, w_rlast_nxt;
   logic          w_ar_hs, w_rd_inrange;
   logic [AW:0]   w_rd_addr;

   assign w_aw_hs     = M_AWVALID & r_awready;
   assign w_w_hs      = M_WVALID & r_wready;
   assign w_waddr     = w_aw_hs ? M_AWADDR : r_awaddr;
   assign w_wdata     = w_w_hs ? M_WDATA : r_wdata;
   assign w_wstrb     = w_w_hs ? M_WSTRB : r_wstrb;
   assign w_w_inrange = (w_waddr < DEPTH_A);

   assign w_ar_hs      = M_ARVALID & r_arready;
   assign w_beat_inc   = r_beat + 4'd1;
   assign w_rd_inrange = (w_rd_addr < DEPTH_X);

   axi_wstrb_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
      .i_clk   (S_ACLK),
      .i_clr   (S_ARESET),
      .i_we    (w_commit & w_w_inrange & ~S_ARESET),
      .i_waddr (w_waddr[IW-1:0]),
      .i_wdata (w_wdata),
      .i_wstrb (w_wstrb),
      .i_raddr (w_rd_addr[IW-1:0]),
      .o_rdata (w_mem_rdata)
   );

   // Write FSM next state: gather AW and W in any order, commit, then hold B.
   always_comb begin
      w_wstate_nxt  = r_wstate;
      w_aw_got_nxt  = r_aw_got;
      w_w_got_nxt   = r_w_got;
      w_awready_nxt = r_awready;
      w_wready_nxt  = r_wready;
      w_bvalid_nxt  = r_bvalid;
      w_bresp_nxt   = r_bresp;
      w_commit      = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_aw_got_nxt = r_aw_got | w_aw_hs;
            w_w_got_nxt  = r_w_got | w_w_hs;
            if (w_aw_got_nxt && w_w_got_nxt) begin
               w_commit      = 1'b1;
               w_wstate_nxt  = W_RESP;
               w_awready_nxt = 1'b0;
               w_wready_nxt  = 1'b0;
               w_bvalid_nxt  = 1'b1;
               w_bresp_nxt   = resp_of(w_w_inrange);
            end else begin
               w_awready_nxt = ~w_aw_got_nxt;
               w_wready_nxt  = ~w_w_got_nxt;
            end
         end
         W_RESP: begin
            if (M_BREADY) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_got_nxt  = 1'b0;
               w_w_got_nxt   = 1'b0;
               w_awready_nxt = 1'b1;
               w_wready_nxt  = 1'b1;
               w_bvalid_nxt  = 1'b0;
            end else begin
               w_wstate_nxt  = W_RESP;
            end
         end
         default: begin
            w_wstate_nxt  = W_IDLE;
            w_aw_got_nxt  = 1'b0;
            w_w_got_nxt   = 1'b0;
            w_awready_nxt = 1'b0;
            w_wready_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b0;
         end
      endcase
   end

   // Write FSM registers and AW/W holding registers.
   always_ff @(posedge S_ACLK) begin
      if (S_ARESET) begin
         r_wstate  <= W_IDLE;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_aw_got  <= w_aw_got_nxt;
         r_w_got   <= w_w_got_nxt;
         r_awaddr  <= w_aw_hs ? M_AWADDR : r_awaddr;
         r_wdata   <= w_w_hs ? M_WDATA : r_wdata;
         r_wstrb   <= w_w_hs ? M_WSTRB : r_wstrb;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_bresp   <= w_bresp_nxt;
      end
   end

   // Address of the beat being loaded: beat 0 on AR, otherwise the next beat.
   always_comb begin
      if (r_rstate == R_IDLE) begin
         w_rd_addr = {1'b0, M_ARADDR};
      end else begin
         w_rd_addr = {1'b0, r_raddr} + {{(AW-3){1'b0}}, w_beat_inc};
      end
   end

   // Read FSM next state and next beat contents.
   always_comb begin
      w_rstate_nxt  = r_rstate;
      w_beat_nxt    = r_beat;
      w_arready_nxt = r_arready;
      w_rvalid_nxt  = r_rvalid;
      w_rdata_nxt   = r_rdata;
      w_rresp_nxt   = r_rresp;
      w_rlast_nxt   = r_rlast;
      case (r_rstate)
         R_IDLE: begin
            if (w_ar_hs) begin
               w_rstate_nxt  = R_DATA;
               w_beat_nxt    = 4'd0;
               w_arready_nxt = 1'b0;
               w_rvalid_nxt  = 1'b1;
               w_rdata_nxt   = w_rd_inrange ? w_mem_rdata : 32'd0;
               w_rresp_nxt   = resp_of(w_rd_inrange);
               w_rlast_nxt   = (M_BLEN == 4'd0);
            end else begin
               w_arready_nxt = 1'b1;
            end
         end
         R_DATA: begin
            if (M_RREADY && r_rlast) begin
               w_rstate_nxt  = R_IDLE;
               w_arready_nxt = 1'b1;
               w_rvalid_nxt  = 1'b0;
               w_rlast_nxt   = 1'b0;
            end else if (M_RREADY) begin
               w_beat_nxt    = w_beat_inc;
               w_rdata_nxt   = w_rd_inrange ? w_mem_rdata : 32'd0;
               w_rresp_nxt   = resp_of(w_rd_inrange);
               w_rlast_nxt   = (w_beat_inc == r_rlen);
            end else begin
               w_rstate_nxt  = R_DATA;
            end
         end
         default: begin
            w_rstate_nxt  = R_IDLE;
            w_arready_nxt = 1'b0;
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
         end
      endcase
   end

   // Read FSM registers and registered R channel outputs.
   always_ff @(posedge S_ACLK) begin
      if (S_ARESET) begin
         r_rstate  <= R_IDLE;
         r_raddr   <= '0;
         r_rlen    <= 4'd0;
         r_beat    <= 4'd0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
         r_rresp   <= 2'b00;
         r_rlast   <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_raddr   <= w_ar_hs ? M_ARADDR : r_raddr;
         r_rlen    <= w_ar_hs ? M_BLEN : r_rlen;
         r_beat    <= w_beat_nxt;
         r_arready <= w_arready_nxt;
         r_rvalid  <= w_rvalid_nxt;
         r_rdata   <= w_rdata_nxt;
         r_rresp   <= w_rresp_nxt;
         r_rlast   <= w_rlast_nxt;
      end
   end

   assign S_AWREADY = r_awready;
   assign S_WREADY  = r_wready;
   assign S_BVALID  = r_bvalid;
   assign S_BRESP   = r_bresp;
   assign S_ARREADY = r_arready;
   assign S_RVALID  = r_rvalid;
   assign S_RDATA   = r_rdata;
   assign S_RRESP   = r_rresp;
   assign S_RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Scoreboard bench for axi_burst_mem_responder: a memory model predicts B
// responses and R beats, which monitors pop and compare on each handshake.
module tb_axi_burst_mem_responder;

   localparam int DEPTH = 16;
   localparam int AW    = 32;

   logic          S_ACLK = 1'b0;
   logic          S_ARESET = 1'b1;
   logic          M_AWVALID = 1'b0;
   logic [AW-1:0] M_AWADDR = '0;
   logic          S_AWREADY;
   logic          M_WVALID = 1'b0;
   logic [31:0]   M_WDATA = 32'd0;
   logic [3:0]    M_WSTRB = 4'd0;
   logic          S_WREADY;
   logic          S_BVALID;
   logic [1:0]    S_BRESP;
   logic          M_BREADY = 1'b0;
   logic          M_ARVALID = 1'b0;
   logic [AW-1:0] M_ARADDR = '0;
   logic [3:0]    M_BLEN = 4'd0;
   logic          S_ARREADY;
   logic          S_RVALID;
   logic [31:0]   S_RDATA;
   logic [1:0]    S_RRESP;
   logic          S_RLAST;
   logic          M_RREADY = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] model [DEPTH];
   logic [1:0]  exp_b_q [$];
   logic [34:0] exp_r_q [$];   // {last, resp, data}

   axi_burst_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .S_ACLK(S_ACLK), .S_ARESET(S_ARESET),
      .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
      .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
      .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
      .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_BLEN(M_BLEN), .S_ARREADY(S_ARREADY),
      .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .M_RREADY(M_RREADY)
   );

   always #5 S_ACLK = ~S_ACLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge S_ACLK);
      #1;
   endtask

   // B channel monitor: compare on each handshake.
   always @(negedge S_ACLK) begin
      if (!S_ARESET && S_BVALID && M_BREADY) begin
         if (exp_b_q.size() == 0) begin
            check("b_unexpected", 64'd1, 64'd0);
         end else begin
            check("bresp", S_BRESP, exp_b_q.pop_front());
         end
      end
   end

   // R channel monitor: compare each beat on handshake.
   always @(negedge S_ACLK) begin
      logic [34:0] e;
      if (!S_ARESET && S_RVALID && M_RREADY) begin
         if (exp_r_q.size() == 0) begin
            check("r_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_r_q.pop_front();
            check("rdata", S_RDATA, e[31:0]);
            check("rresp", S_RRESP, e[33:32]);
            check("rlast", S_RLAST, e[34]);
         end
      end
   end

   task automatic write_tx(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_delay);
      logic [1:0] exp_resp;
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      exp_resp = (addr < DEPTH) ? 2'b00 : 2'b10;
      if (addr < DEPTH) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr][8*b +: 8] = data[8*b +: 8];
         end
      end
      exp_b_q.push_back(exp_resp);
      M_WDATA = data; M_WSTRB = strb; M_WVALID = 1'b1; M_AWADDR = addr;
      if (w_lead == 0) M_AWVALID = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 40) begin
         @(negedge S_ACLK);
         aw_hs = M_AWVALID && S_AWREADY;
         w_hs  = M_WVALID && S_WREADY;
         @(posedge S_ACLK); #1;
         if (aw_hs) begin aw_done = 1'b1; M_AWVALID = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; M_WVALID  = 1'b0; end
         n++;
         if (w_lead > 0 && n == w_lead) M_AWVALID = 1'b1;
         if (w_done && !aw_done) begin
            check("wready_drop", S_WREADY, 64'd0);
            check("bvalid_early", S_BVALID, 64'd0);
         end
      end
      check("wr_hs_done", aw_done && w_done, 64'd1);
      check("b_latency", S_BVALID, 64'd1);
      for (int i = 0; i < b_delay; i++) begin
         @(negedge S_ACLK);
         check("b_hold_valid", S_BVALID, 64'd1);
         check("b_hold_resp", S_BRESP, exp_resp);
         check("b_hold_awready", S_AWREADY, 64'd0);
         check("b_hold_wready", S_WREADY, 64'd0);
         @(posedge S_ACLK); #1;
      end
      M_BREADY = 1'b1;
      tick();
      M_BREADY = 1'b0;
      check("b_done", S_BVALID, 64'd0);
      check("awready_ret", S_AWREADY, 64'd1);
      check("wready_ret", S_WREADY, 64'd1);
   endtask

   task automatic read_tx(input logic [31:0] addr, input logic [3:0] blen, input bit toggle);
      logic [32:0] a;
      logic [34:0] hold;
      bit done, hs, held;
      int n, beats;
      for (int k = 0; k <= int'(blen); k++) begin
         a = {1'b0, addr} + 33'(k);
         if (a < DEPTH) exp_r_q.push_back({(k == int'(blen)), 2'b00, model[a[3:0]]});
         else           exp_r_q.push_back({(k == int'(blen)), 2'b10, 32'd0});
      end
      M_ARADDR = addr; M_BLEN = blen; M_ARVALID = 1'b1;
      done = 1'b0; n = 0;
      while (!done && n < 20) begin
         @(negedge S_ACLK);
         hs = S_ARREADY;
         @(posedge S_ACLK); #1;
         if (hs) begin done = 1'b1; M_ARVALID = 1'b0; end
         n++;
      end
      check("ar_hs_done", done, 64'd1);
      check("r_latency", S_RVALID, 64'd1);
      beats = 0; n = 0; held = 1'b0;
      while (beats <= int'(blen) && n < 100) begin
         M_RREADY = toggle ? (n % 2 == 0) : 1'b1;
         @(negedge S_ACLK);
         if (S_RVALID && M_RREADY) beats++;
         else if (S_RVALID) begin hold = {S_RLAST, S_RRESP, S_RDATA}; held = 1'b1; end
         @(posedge S_ACLK); #1;
         if (held) check("r_stall_hold", {S_RLAST, S_RRESP, S_RDATA}, hold);
         held = 1'b0;
         n++;
      end
      M_RREADY = 1'b0;
      check("r_beats", beats, int'(blen) + 1);
      check("r_done", S_RVALID, 64'd0);
      check("arready_ret", S_ARREADY, 64'd1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      tick(); tick(); tick();
      check("rst_awready", S_AWREADY, 64'd0);
      check("rst_wready", S_WREADY, 64'd0);
      check("rst_arready", S_ARREADY, 64'd0);
      check("rst_bvalid", S_BVALID, 64'd0);
      check("rst_rvalid", S_RVALID, 64'd0);
      check("rst_rlast", S_RLAST, 64'd0);
      check("rst_rdata", S_RDATA, 64'd0);
      S_ARESET = 1'b0;
      tick();
      check("post_rst_awready", S_AWREADY, 64'd1);
      check("post_rst_wready", S_WREADY, 64'd1);
      check("post_rst_arready", S_ARREADY, 64'd1);

      // Byte write, word read
      write_tx(32'd0, 32'h12345678, 4'b0001, 0, 0);
      read_tx(32'd0, 4'd0, 1'b0);

      // Split AW/W, then byte merge
      write_tx(32'd1, 32'h87654321, 4'b0011, 3, 0);
      write_tx(32'd1, 32'h45758264, 4'b0111, 0, 0);
      read_tx(32'd1, 4'd0, 1'b0);

      // Back-pressured B
      write_tx(32'd2, 32'hDEADBEEF, 4'b1111, 0, 5);

      // Burst with RREADY stalls
      for (int i = 0; i < 4; i++) write_tx(32'(i), 32'hA0 + 32'(i), 4'b1111, 0, 0);
      read_tx(32'd0, 4'd3, 1'b1);

      // Out-of-range write and read
      write_tx(32'd14, 32'h0E0E0E0E, 4'b1111, 0, 0);
      write_tx(32'd15, 32'h0F0F0F0F, 4'b1111, 0, 0);
      write_tx(32'd20, 32'hFFFFFFFF, 4'b1111, 0, 0);
      read_tx(32'd14, 4'd3, 1'b0);
      read_tx(32'd0, 4'd3, 1'b0);

      // Reset during beat 2 of a 4-beat burst
      for (int k = 0; k < 4; k++) exp_r_q.push_back({(k == 3), 2'b00, model[k]});
      M_ARADDR = 32'd0; M_BLEN = 4'd3; M_ARVALID = 1'b1;
      tick();
      M_ARVALID = 1'b0; M_RREADY = 1'b1;
      tick(); tick();
      check("rst_mid_beat2", S_RDATA, 64'h000000A2);
      M_RREADY = 1'b0; S_ARESET = 1'b1;
      exp_r_q.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      tick();
      check("rst_mid_rvalid", S_RVALID, 64'd0);
      check("rst_mid_rlast", S_RLAST, 64'd0);
      check("rst_mid_arready", S_ARREADY, 64'd0);
      check("rst_mid_rdata", S_RDATA, 64'd0);
      tick();
      S_ARESET = 1'b0;
      tick();
      check("rst_release_arready", S_ARREADY, 64'd1);

      // Cleared memory and a full 16-beat burst
      write_tx(32'd5, 32'h55AA55AA, 4'b1111, 0, 0);
      read_tx(32'd0, 4'd15, 1'b0);
      check("b_queue_empty", exp_b_q.size(), 64'd0);
      check("r_queue_empty", exp_r_q.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
